muldiv_seq: RTL

Iterative multi-cycle sequencer for the RV32M multiply/divide instructions, sitting beside the single-cycle ALU in the execute stage. It accepts one operation on a start pulse, runs a radix-2 shift-add multiply or restoring divide over WIDTH iterations, and returns the result with a one-cycle done pulse. While it works it holds `busy` high so the hazard logic can stall the pipeline.

---
 rtl/muldiv_seq_if.sv | 32 +++
 rtl/muldiv_seq.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq_if.sv
// Request/response bundle between the execute stage and the multi-cycle mul/div unit.
// Latency: n/a (wiring only); the unit answers WIDTH+2 cycles after start, or 1 cycle for special cases.
// Backpressure: none; the requester must watch busy and must not rely on start being queued.
//
// Signals:
//   start/funct3/op_a/op_b : operation request, sampled only while the unit is idle
//   flush                  : abort whatever is in flight
//   busy/done/result       : unit status, one-cycle completion pulse, registered result word
interface muldiv_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       funct3;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  // Pipeline side: issues operations, observes status.
  modport master (
    output start, funct3, op_a, op_b, flush,
    input  busy, done, result
  );

  // Sequencer side.
  modport slave (
    input  start, funct3, op_a, op_b, flush,
    output busy, done, result
  );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer: radix-2 shift-add multiply, restoring divide.
// Latency: done at start+WIDTH+2 cycles; divide-by-zero and signed overflow finish at start+1.
// Backpressure: busy high while working; start outside IDLE is dropped, flush aborts to IDLE.
//
// Ports:
//   i_clk  : clock, all state on the rising edge
//   i_rst  : synchronous active-high reset, overrides flush and start
//   io_md  : muldiv_seq_if slave (start/funct3/op_a/op_b/flush in, busy/done/result out)
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  muldiv_seq_if.slave  io_md
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CW-1:0]      r_cnt;
  logic [2:0]         r_op;
  logic               r_neg;
  logic [2*WIDTH-1:0] r_prod;     // {high accumulator, remaining multiplier bits}
  logic [WIDTH-1:0]   r_mcand;
  // The partial remainder is always below the divisor, so WIDTH bits hold it;
  // the WIDTH+1-bit shifted value only exists combinationally for the trial subtract.
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quot;     // dividend bits shift out the top, quotient bits shift in
  logic [WIDTH-1:0]   r_divisor;
  logic [WIDTH-1:0]   r_result;

  // ---------------- request decode (IDLE) ----------------
  logic             w_signed_a;
  logic             w_signed_b;
  logic             w_a_neg;
  logic             w_b_neg;
  logic             w_sign;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic             w_div_zero;
  logic             w_ovf;
  logic             w_special;
  logic [WIDTH-1:0] w_special_res;

  always_comb begin
    w_signed_a = 1'b0;
    w_signed_b = 1'b0;
    case (io_md.funct3)
      3'b001, 3'b100, 3'b110: begin w_signed_a = 1'b1; w_signed_b = 1'b1; end
      3'b010:                 begin w_signed_a = 1'b1; end
      default:                ;
    endcase
  end

  assign w_a_neg = w_signed_a & io_md.op_a[WIDTH-1];
  assign w_b_neg = w_signed_b & io_md.op_b[WIDTH-1];
  assign w_mag_a = w_a_neg ? -io_md.op_a : io_md.op_a;
  assign w_mag_b = w_b_neg ? -io_md.op_b : io_md.op_b;
  // REM follows the dividend; every other signed op uses the XOR of operand signs.
  assign w_sign  = (io_md.funct3 == 3'b110) ? w_a_neg : (w_a_neg ^ w_b_neg);

  assign w_div_zero = io_md.funct3[2] && (io_md.op_b == '0);
  assign w_ovf      = io_md.funct3[2] && !io_md.funct3[0]
                      && (io_md.op_a == {1'b1, {(WIDTH-1){1'b0}}})
                      && (io_md.op_b == '1);
  assign w_special  = w_div_zero | w_ovf;
  // Overflow DIV returns the dividend itself (the most negative value), REM returns 0.
  assign w_special_res = w_div_zero ? (io_md.funct3[1] ? io_md.op_a : '1)
                                    : (io_md.funct3[1] ? '0 : io_md.op_a);

  // ---------------- one iteration (CALC) ----------------
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_prod_nxt;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH:0]     w_rem_diff;
  logic               w_q_bit;

  assign w_mul_sum  = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
  assign w_prod_nxt = {w_mul_sum, r_prod[WIDTH-1:1]};
  assign w_rem_sh   = {r_rem, r_quot[WIDTH-1]};
  assign w_rem_diff = w_rem_sh - {1'b0, r_divisor};
  assign w_q_bit    = ~w_rem_diff[WIDTH];

  // ---------------- sign fix and word select (FIX) ----------------
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quot_fix;
  logic [WIDTH-1:0]   w_rem_fix;
  logic [WIDTH-1:0]   w_fix_res;

  assign w_prod_fix = r_neg ? -r_prod : r_prod;
  assign w_quot_fix = r_neg ? -r_quot : r_quot;
  assign w_rem_fix  = r_neg ? -r_rem  : r_rem;

  always_comb begin
    w_fix_res = w_prod_fix[2*WIDTH-1:WIDTH];
    case (r_op)
      3'b000:         w_fix_res = w_prod_fix[WIDTH-1:0];
      3'b100, 3'b101: w_fix_res = w_quot_fix;
      3'b110, 3'b111: w_fix_res = w_rem_fix;
      default:        w_fix_res = w_prod_fix[2*WIDTH-1:WIDTH];
    endcase
  end

  // ---------------- FSM ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (io_md.start) w_state_nxt = w_special ? S_DONE : S_CALC;
      S_CALC: if (r_cnt == CW'(WIDTH-1)) w_state_nxt = S_FIX;
      S_FIX:  w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (io_md.flush) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_op      <= '0;
      r_neg     <= 1'b0;
      r_prod    <= '0;
      r_mcand   <= '0;
      r_rem     <= '0;
      r_quot    <= '0;
      r_divisor <= '0;
      r_result  <= '0;
    end else begin
      r_state <= w_state_nxt;
      // Datapath only advances when not flushed, so a flush leaves result untouched.
      if (!io_md.flush) begin
        case (r_state)
          S_IDLE: begin
            if (io_md.start) begin
              r_op      <= io_md.funct3;
              r_neg     <= w_sign;
              r_cnt     <= '0;
              r_prod    <= {{WIDTH{1'b0}}, w_mag_b};
              r_mcand   <= w_mag_a;
              r_rem     <= '0;
              r_quot    <= w_mag_a;
              r_divisor <= w_mag_b;
              if (w_special) r_result <= w_special_res;
            end
          end
          S_CALC: begin
            r_cnt <= r_cnt + CW'(1);
            if (r_op[2]) begin
              r_rem  <= w_q_bit ? w_rem_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
              r_quot <= {r_quot[WIDTH-2:0], w_q_bit};
            end else begin
              r_prod <= w_prod_nxt;
            end
          end
          S_FIX: r_result <= w_fix_res;
          default: ;
        endcase
      end
    end
  end

  assign io_md.busy   = (r_state != S_IDLE);
  assign io_md.done   = (r_state == S_DONE);
  assign io_md.result = r_result;

endmodule
